cam_pix_capture: RTL and testbench



---
 rtl/cam_pix_capture_if.sv | 22 ++
 rtl/cam_pix_capture.sv | 175 +++++++++++++++++
 tb/tb_cam_pix_capture.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_pix_capture_if.sv
// Write port of the camera FIFO that feeds the frame-buffer burst writer.
// master = pixel producer (cam_pix_capture), slave = FIFO.
interface cam_pix_capture_if;
  // Handshake: wrreq_cam is a one-cycle write strobe qualifying cam_wr_data.
  // The producer only raises it for a pixel that completed while wrfull_cam
  // was low; a pixel completing while full is dropped and never retried.
  logic        wrreq_cam;
  logic [15:0] cam_wr_data;
  logic        wrfull_cam;

  modport master (
    output wrreq_cam,
    output cam_wr_data,
    input  wrfull_cam
  );

  modport slave (
    input  wrreq_cam,
    input  cam_wr_data,
    output wrfull_cam
  );
endinterface

// File: rtl/cam_pix_capture.sv
// Camera parallel-bus capture: byte pairs -> RGB565 pixels into the camera FIFO,
// with frame/line framing and sticky error flags. Optional: CAM_CAP_TEST_PATTERN_EN.
module cam_pix_capture #(
  parameter int   LINE_PIX  = 640,
  parameter int   NUM_LINE  = 480,
  parameter logic VSYNC_ACT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cap_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        err_clr,
`ifdef CAM_CAP_TEST_PATTERN_EN
  input  logic        tp_sel,
`endif
  cam_pix_capture_if.master fifo,
  output logic        frame_start,
  output logic        frame_done,
  output logic [9:0]  pix_cnt,
  output logic [8:0]  line_cnt,
  output logic [31:0] frame_num,
  output logic        ovf,
  output logic        line_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [9:0] LINE_PIX_C = 10'(LINE_PIX);
  localparam logic [8:0] NUM_LINE_C = 9'(NUM_LINE);

  state_t      state;
  logic        vs_q;
  logic        href_q;
  logic        phase;
  logic        started;
  logic [7:0]  b0;

  logic        vs_act;
  logic        vs_q_act;
  logic        href_rise;
  logic        line_room;
  logic        pix_room;
  logic        line_end;
  logic        exit_cap;
  logic        byte_ok;
  logic        eff_phase;
  logic [15:0] pix_word;

  assign vs_act    = (cam_vsync == VSYNC_ACT);
  assign vs_q_act  = (vs_q == VSYNC_ACT);
  assign href_rise = cam_href & ~href_q;
  assign line_room = (line_cnt < NUM_LINE_C);
  assign pix_room  = (pix_cnt < LINE_PIX_C);

  // A VSYNC arriving while href is still high closes the open line first.
  assign line_end  = href_q & (~cam_href | vs_act);
  assign exit_cap  = vs_act | (~line_room & ~cam_href);

  // Bytes are ignored once the frame is full or VSYNC has started.
  assign byte_ok   = cam_href & ~vs_act & line_room;
  assign eff_phase = href_rise ? 1'b0 : phase;

`ifdef CAM_CAP_TEST_PATTERN_EN
  assign pix_word = tp_sel ? {line_cnt[4:0], pix_cnt[5:0], line_cnt[4:0]}
                           : {b0, cam_data};
`else
  assign pix_word = {b0, cam_data};
`endif

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= WAIT_VS;
      vs_q             <= ~VSYNC_ACT;
      href_q           <= 1'b0;
      phase            <= 1'b0;
      started          <= 1'b0;
      b0               <= 8'd0;
      fifo.wrreq_cam   <= 1'b0;
      fifo.cam_wr_data <= 16'd0;
      frame_start      <= 1'b0;
      frame_done       <= 1'b0;
      pix_cnt          <= 10'd0;
      line_cnt         <= 9'd0;
      frame_num        <= 32'd0;
      ovf              <= 1'b0;
      line_err         <= 1'b0;
      busy             <= 1'b0;
    end else begin
      vs_q           <= cam_vsync;
      href_q         <= cam_href;
      fifo.wrreq_cam <= 1'b0;
      frame_start    <= 1'b0;
      frame_done     <= 1'b0;

      // Clear first so a same-cycle error assignment below takes precedence.
      if (err_clr) begin
        ovf      <= 1'b0;
        line_err <= 1'b0;
      end

      case (state)
        WAIT_VS: begin
          if (vs_act) state <= ARM;
        end

        ARM: begin
          if (!vs_act && vs_q_act) begin
            if (cap_en) begin
              state    <= CAPTURE;
              busy     <= 1'b1;
              line_cnt <= 9'd0;
              pix_cnt  <= 10'd0;
              phase    <= 1'b0;
              started  <= 1'b0;
            end else begin
              state <= WAIT_VS;
            end
          end
        end

        CAPTURE: begin
          if (byte_ok) begin
            if (!started) begin
              frame_start <= 1'b1;
              started     <= 1'b1;
            end
            if (!eff_phase) begin
              b0    <= cam_data;
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              // Dropped pixels still advance pix_cnt so line geometry holds.
              if (pix_room) begin
                pix_cnt <= pix_cnt + 10'd1;
                if (fifo.wrfull_cam) begin
                  ovf <= 1'b1;
                end else begin
                  fifo.wrreq_cam   <= 1'b1;
                  fifo.cam_wr_data <= pix_word;
                end
              end
            end
          end

          if (line_end && line_room) begin
            phase    <= 1'b0;
            pix_cnt  <= 10'd0;
            line_cnt <= line_cnt + 9'd1;
            if (pix_cnt != LINE_PIX_C) line_err <= 1'b1;
          end

          if (exit_cap) begin
            frame_done <= 1'b1;
            frame_num  <= frame_num + 32'd1;
            busy       <= 1'b0;
            state      <= ARM;
          end
        end

        default: state <= WAIT_VS;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_pix_capture.sv
// Bench for cam_pix_capture on a reduced geometry (8 pixels x 6 lines) with a
// scoreboard of expected FIFO words.
module tb_cam_pix_capture;
  localparam int LP = 8;
  localparam int NL = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cap_en = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic        err_clr = 1'b0;
`ifdef CAM_CAP_TEST_PATTERN_EN
  logic        tp_sel = 1'b0;
`endif
  logic        frame_start, frame_done, ovf, line_err, busy;
  logic [9:0]  pix_cnt;
  logic [8:0]  line_cnt;
  logic [31:0] frame_num;
  logic [1:0]  dbg_state;

  cam_pix_capture_if fifo_if ();

  cam_pix_capture #(.LINE_PIX(LP), .NUM_LINE(NL), .VSYNC_ACT(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .cap_en      (cap_en),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .err_clr     (err_clr),
`ifdef CAM_CAP_TEST_PATTERN_EN
    .tp_sel      (tp_sel),
`endif
    .fifo        (fifo_if),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .pix_cnt     (pix_cnt),
    .line_cnt    (line_cnt),
    .frame_num   (frame_num),
    .ovf         (ovf),
    .line_err    (line_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int fs_cnt = 0;
  int fd_cnt = 0;
  int last_pix = 0;
  int exp_frames = 0;
  int cur_line = 0;
  bit tp_mode = 1'b0;

  always @(negedge clk) begin
    if (fifo_if.wrreq_cam === 1'b1) begin
      logic [15:0] exp_w;
      wr_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got write %h, expected no write", fifo_if.cam_wr_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (fifo_if.cam_wr_data !== exp_w) begin
          bad++;
          $display("FAIL wr_data: got %h want %h", fifo_if.cam_wr_data, exp_w);
        end
      end
    end
    if (frame_start === 1'b1) fs_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_line(input int nbytes, input bit cap, input int full_at,
                           input int full_len, input int clr_at, input bit vs_end);
    logic [7:0] b0;
    logic [7:0] d;
    logic [4:0] ln;
    logic [5:0] px;
    b0 = 8'd0;
    for (int b = 0; b < nbytes; b++) begin
      d = 8'($urandom_range(0, 255));
      cam_href = 1'b1;
      cam_data = d;
      fifo_if.wrfull_cam = (b >= full_at) && (b < full_at + full_len);
      err_clr = (b == clr_at);
      if (b % 2 == 0) begin
        b0 = d;
      end else if (cap && (b / 2) < LP && !fifo_if.wrfull_cam) begin
        ln = 5'(cur_line);
        px = 6'(b / 2);
        exp_q.push_back(tp_mode ? {ln, px, ln} : {b0, d});
      end
      tick();
    end
    last_pix = int'(pix_cnt);
    fifo_if.wrfull_cam = 1'b0;
    err_clr = 1'b0;
    if (vs_end) begin
      cam_vsync = 1'b1;
      cam_data = 8'hEE;
      tick();
    end
    cam_href = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_timeout: busy=%b after %0d cycles, want 0", busy, n); end
  endtask

  task automatic run_frame(input bit cap);
    vsync_pulse();
    for (int i = 0; i < NL; i++) begin
      cur_line = i;
      send_line(2 * LP, cap, -1, 0, -1, 1'b0);
    end
    wait_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) tick();
    total++;
    if ({fifo_if.wrreq_cam, fifo_if.cam_wr_data, frame_start, frame_done, pix_cnt, line_cnt,
         frame_num, ovf, line_err, busy} !== 73'd0) begin
      bad++; $display("FAIL reset_outputs: got nonzero outputs, want all zero");
    end
    reset = 1'b1;
    repeat (2) tick();
    total++;
    if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_nominal();
    cap_en = 1'b1; wr_cnt = 0; fs_cnt = 0; fd_cnt = 0;
    vsync_pulse();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL nominal_busy: got %b want 1", busy); end
    for (int i = 0; i < NL; i++) begin
      cur_line = i;
      send_line(2 * LP, 1'b1, -1, 0, -1, 1'b0);
      total++;
      if (last_pix != LP) begin bad++; $display("FAIL nominal_pix_cnt: line %0d got %0d want %0d", i, last_pix, LP); end
      total++;
      if (line_cnt !== 9'(i + 1)) begin bad++; $display("FAIL nominal_line_cnt: got %0d want %0d", line_cnt, i + 1); end
    end
    wait_idle();
    exp_frames++;
    total++;
    if (wr_cnt != NL * LP) begin bad++; $display("FAIL nominal_writes: got %0d want %0d", wr_cnt, NL * LP); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL nominal_queue: got %0d left want 0", exp_q.size()); end
    total++;
    if (fs_cnt != 1 || fd_cnt != 1) begin bad++; $display("FAIL nominal_pulses: got start=%0d done=%0d want 1/1", fs_cnt, fd_cnt); end
    total++;
    if (frame_num !== 32'(exp_frames)) begin bad++; $display("FAIL nominal_frame_num: got %0d want %0d", frame_num, exp_frames); end
    total++;
    if (ovf !== 1'b0 || line_err !== 1'b0) begin bad++; $display("FAIL nominal_flags: got ovf=%b line_err=%b want 0/0", ovf, line_err); end
    total++;
    if (dbg_state !== 2'd1) begin bad++; $display("FAIL nominal_state: got %0d want 1", dbg_state); end
  endtask

  task automatic test_fifo_full();
    wr_cnt = 0;
    vsync_pulse();
    for (int i = 0; i < NL; i++) begin
      cur_line = i;
      if (i == 5) send_line(2 * LP, 1'b1, 4, 10, -1, 1'b0);
      else send_line(2 * LP, 1'b1, -1, 0, -1, 1'b0);
      if (i == 5) begin
        total++;
        if (last_pix != LP) begin bad++; $display("FAIL full_pix_cnt: got %0d want %0d", last_pix, LP); end
        total++;
        if (ovf !== 1'b1) begin bad++; $display("FAIL full_ovf_set: got %b want 1", ovf); end
      end
    end
    wait_idle();
    exp_frames++;
    total++;
    if (wr_cnt != NL * LP - 5) begin bad++; $display("FAIL full_writes: got %0d want %0d", wr_cnt, NL * LP - 5); end
    total++;
    if (line_cnt !== 9'(NL) || line_err !== 1'b0) begin bad++; $display("FAIL full_geometry: got line_cnt=%0d line_err=%b want %0d/0", line_cnt, line_err, NL); end
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL full_ovf_clr: got %b want 0", ovf); end
  endtask

  task automatic test_err_clr_race();
    wr_cnt = 0;
    vsync_pulse();
    for (int i = 0; i < NL; i++) begin
      cur_line = i;
      if (i == 0) send_line(2 * LP, 1'b1, 2, 2, 3, 1'b0);
      else send_line(2 * LP, 1'b1, -1, 0, -1, 1'b0);
      if (i == 0) begin
        total++;
        if (ovf !== 1'b1) begin bad++; $display("FAIL race_ovf: got %b want 1", ovf); end
      end
    end
    wait_idle();
    exp_frames++;
    total++;
    if (wr_cnt != NL * LP - 1) begin bad++; $display("FAIL race_writes: got %0d want %0d", wr_cnt, NL * LP - 1); end
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
  endtask

  task automatic test_short_long();
    wr_cnt = 0;
    vsync_pulse();
    for (int i = 0; i < NL; i++) begin
      cur_line = i;
      if (i == 1) send_line(2 * LP + 4, 1'b1, -1, 0, -1, 1'b0);
      else if (i == 3) send_line(2 * LP - 1, 1'b1, -1, 0, -1, 1'b0);
      else send_line(2 * LP, 1'b1, -1, 0, -1, 1'b0);
      if (i == 1) begin
        total++;
        if (last_pix != LP || line_err !== 1'b0) begin bad++; $display("FAIL long_line: got pix=%0d line_err=%b want %0d/0", last_pix, line_err, LP); end
      end
      if (i == 3) begin
        total++;
        if (last_pix != LP - 1 || line_err !== 1'b1) begin bad++; $display("FAIL short_line: got pix=%0d line_err=%b want %0d/1", last_pix, line_err, LP - 1); end
      end
      if (i == 4) begin
        total++;
        if (last_pix != LP) begin bad++; $display("FAIL after_short: got pix=%0d want %0d", last_pix, LP); end
      end
    end
    wait_idle();
    exp_frames++;
    total++;
    if (wr_cnt != NL * LP - 1 || exp_q.size() != 0) begin bad++; $display("FAIL short_writes: got %0d (queue %0d) want %0d (0)", wr_cnt, exp_q.size(), NL * LP - 1); end
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    total++;
    if (line_err !== 1'b0) begin bad++; $display("FAIL line_err_clr: got %b want 0", line_err); end
  endtask

  task automatic test_enable();
    // cap_en dropped mid-frame: the running frame still completes
    wr_cnt = 0;
    cap_en = 1'b1;
    vsync_pulse();
    for (int i = 0; i < NL; i++) begin
      cur_line = i;
      if (i == 3) cap_en = 1'b0;
      send_line(2 * LP, 1'b1, -1, 0, -1, 1'b0);
    end
    wait_idle();
    exp_frames++;
    total++;
    if (wr_cnt != NL * LP) begin bad++; $display("FAIL disable_writes: got %0d want %0d", wr_cnt, NL * LP); end
    // cap_en raised mid-frame: nothing until the next frame boundary
    wr_cnt = 0;
    vsync_pulse();
    for (int i = 0; i < NL; i++) begin
      cur_line = i;
      if (i == 1) cap_en = 1'b1;
      send_line(2 * LP, 1'b0, -1, 0, -1, 1'b0);
    end
    total++;
    if (wr_cnt != 0 || busy !== 1'b0) begin bad++; $display("FAIL midenable_idle: got writes=%0d busy=%b want 0/0", wr_cnt, busy); end
    total++;
    if (dbg_state !== 2'd0) begin bad++; $display("FAIL midenable_state: got %0d want 0", dbg_state); end
    total++;
    if (frame_num !== 32'(exp_frames)) begin bad++; $display("FAIL midenable_frame_num: got %0d want %0d", frame_num, exp_frames); end
    run_frame(1'b1);
    exp_frames++;
    total++;
    if (wr_cnt != NL * LP || frame_num !== 32'(exp_frames)) begin bad++; $display("FAIL enable_next_frame: got writes=%0d frames=%0d want %0d/%0d", wr_cnt, frame_num, NL * LP, exp_frames); end
  endtask

  task automatic test_vsync_mid_line();
    wr_cnt = 0; fd_cnt = 0;
    cap_en = 1'b1;
    vsync_pulse();
    for (int i = 0; i < 3; i++) begin
      cur_line = i;
      if (i == 2) send_line(7, 1'b1, -1, 0, -1, 1'b1);
      else send_line(2 * LP, 1'b1, -1, 0, -1, 1'b0);
    end
    exp_frames++;
    total++;
    if (wr_cnt != 2 * LP + 3) begin bad++; $display("FAIL vs_writes: got %0d want %0d", wr_cnt, 2 * LP + 3); end
    total++;
    if (line_cnt !== 9'd3 || line_err !== 1'b1 || pix_cnt !== 10'd0) begin bad++; $display("FAIL vs_line_end: got line_cnt=%0d line_err=%b pix=%0d want 3/1/0", line_cnt, line_err, pix_cnt); end
    total++;
    if (fd_cnt != 1 || busy !== 1'b0 || frame_num !== 32'(exp_frames)) begin bad++; $display("FAIL vs_frame_done: got done=%0d busy=%b frames=%0d want 1/0/%0d", fd_cnt, busy, frame_num, exp_frames); end
    cap_en = 1'b0;
    cam_vsync = 1'b0;
    repeat (3) tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
  endtask

`ifdef CAM_CAP_TEST_PATTERN_EN
  task automatic test_pattern();
    wr_cnt = 0;
    cap_en = 1'b1; tp_sel = 1'b1; tp_mode = 1'b1;
    run_frame(1'b1);
    exp_frames++;
    total++;
    if (wr_cnt != NL * LP || exp_q.size() != 0) begin bad++; $display("FAIL pattern_writes: got %0d (queue %0d) want %0d", wr_cnt, exp_q.size(), NL * LP); end
    tp_sel = 1'b0; tp_mode = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    cap_en = 1'b1;
    vsync_pulse();
    for (int i = 0; i < 2; i++) begin
      cur_line = i;
      send_line(2 * LP, 1'b1, -1, 0, -1, 1'b0);
    end
    cam_href = 1'b1; cam_data = 8'h11;
    tick();
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    exp_frames = 0;
    total++;
    if ({fifo_if.wrreq_cam, fifo_if.cam_wr_data, frame_start, frame_done, pix_cnt, line_cnt,
         frame_num, ovf, line_err, busy} !== 73'd0) begin
      bad++; $display("FAIL midreset_outputs: got nonzero outputs, want all zero");
    end
    total++;
    if (dbg_state !== 2'd0) begin bad++; $display("FAIL midreset_state: got %0d want 0", dbg_state); end
    @(posedge clk); #1;
    reset = 1'b1;
    wr_cnt = 0;
    for (int i = 2; i < NL; i++) begin
      cur_line = i;
      send_line(2 * LP, 1'b0, -1, 0, -1, 1'b0);
    end
    total++;
    if (wr_cnt != 0 || busy !== 1'b0 || frame_num !== 32'd0) begin bad++; $display("FAIL midreset_idle: got writes=%0d busy=%b frames=%0d want 0/0/0", wr_cnt, busy, frame_num); end
    run_frame(1'b1);
    exp_frames++;
    total++;
    if (wr_cnt != NL * LP || frame_num !== 32'(exp_frames)) begin bad++; $display("FAIL midreset_resume: got writes=%0d frames=%0d want %0d/%0d", wr_cnt, frame_num, NL * LP, exp_frames); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    fifo_if.wrfull_cam = 1'b0;
    test_reset();
    test_nominal();
    test_fifo_full();
    test_err_clr_race();
    test_short_long();
    test_enable();
    test_vsync_mid_line();
`ifdef CAM_CAP_TEST_PATTERN_EN
    test_pattern();
`endif
    test_reset_mid();
    repeat (4) tick();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL final_queue: got %0d pending want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: simulation did not complete, time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
